// File: rtl/mux16_rr_arbiter_if.sv
// Bus between the requesters and the 16:1 mux round-robin arbiter.
//
// Handshake: the requesters raise req[i] and hold it for as long as they want
// the path. gnt/sel/sel_valid say who owns it: sel is meaningful only while
// sel_valid is 1, and sel_valid == |gnt. beat means "the downstream accepted one
// transfer through the mux this cycle". It is counted only while the current
// owner still holds its req bit. burst_cnt reports the beats accepted so far in
// the current grant.
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic        beat;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        sel_valid;
    logic [7:0]  burst_cnt;

    // Requester / downstream side
    modport master (
        output req,
        output beat,
        input  gnt,
        input  sel,
        input  sel_valid,
        input  burst_cnt
    );

    // Arbiter side
    modport slave (
        input  req,
        input  beat,
        output gnt,
        output sel,
        output sel_valid,
        output burst_cnt
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 16:1 select datapath.
// The arbiter picks one owner from IDLE, keeping its search pointer. It holds
// the grant until the owner drops req or reaches MAX_BURST qualified beats.
// It then inserts one idle cycle and moves the pointer past the old owner.
module mux16_rr_arbiter #(
    parameter int NREQ      = 16,
    parameter int SELW      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux16_rr_arbiter_if.slave     bus,
    output logic                  state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [SELW-1:0]   ptr;
    logic [NREQ-1:0]   gnt_q;
    logic [SELW-1:0]   sel_q;
    logic              sel_valid_q;
    logic [7:0]        cnt_q;

    logic              win_found;
    logic [SELW-1:0]   win_idx;
    logic [SELW-1:0]   scan_idx;
    logic              own_req;

    // Rotating priority search: first requester at or after ptr, wrapping mod 16
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ptr + SELW'(i);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Owner still requesting; beats only count while this is true
    always_comb begin
        own_req = bus.req[sel_q];
    end

    // Two-state grant FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= GRANT;
                        gnt_q       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        sel_q       <= win_idx;
                        sel_valid_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                GRANT: begin
                    // Dropping req wins over a same-cycle beat; the terminal
                    // beat releases instead of storing MAX_BURST in the counter.
                    if (!own_req || (bus.beat && cnt_q == 8'(MAX_BURST - 1))) begin
                        state       <= IDLE;
                        gnt_q       <= '0;
                        sel_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        ptr         <= sel_q + 1'b1;
                    end else if (bus.beat) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    gnt_q       <= '0;
                    sel_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.burst_cnt = cnt_q;
    assign state_dbg     = state;

endmodule
